vga_code_sched: RTL and testbench
=================================

Name: vga_code_sched

Overview:
- Sequences the 24-bit two-half colour code consumed by the `vga` block: `[23:12]` is the left half RGB, `[11:0]` is the right half RGB.
- Two requesters (CPU path A, debug/switch path B) submit codes over valid/ready. Round-robin arbitration pushes the codes into a small FIFO.
- The block pops one code per frame boundary, no more often than every `hold_frames` frames, and drives it onto `code`.
- It keeps its own frame timing, reset-aligned with `vga`, so `code` only changes on the same edge where `vga` samples it.

Parameters:
- `CODE_W`, 24, width of one colour code.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `H_TOTAL`, 1040, pixel clocks per line (800x600@72Hz, 50 MHz).
- `V_TOTAL`, 666, lines per frame.

Ports:
- `clk`  in  1  pixel clock, 50 MHz, shared with `vga`.
- `rst_n`  in  1  reset, asynchronous, active-low; same net as `vga`.
- `a_valid`  in  1  requester A has a code.
- `a_code`  in  `CODE_W`  requester A code.
- `a_ready`  out  1  A accepted this cycle.
- `b_valid`  in  1  requester B has a code.
- `b_code`  in  `CODE_W`  requester B code.
- `b_ready`  out  1  B accepted this cycle.
- `hold_frames`  in  8  minimum frames between pops; 0 is treated as 1; sampled at pop.
- `flush`  in  1  synchronous clear of FIFO and hold timer.
- `code`  out  `CODE_W`  code presented to `vga`.
- `frame_end`  out  1  high during the last cycle of a frame.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset is asynchronous and active-low. Reset values: `h_cnt=0`, `v_cnt=0`, `code=0`, `level=0`, `hold_rem=0`, `rr_ptr=A`, FIFO pointers 0.
  - Outputs in reset: `a_ready=0`, `b_ready=0`, `frame_end=0`.
  - Reset mid-operation discards all queued codes.
- Frame timing:
  - `h_cnt` counts 0..H_TOTAL-1; it wraps to 0 and increments `v_cnt`.
  - `v_cnt` counts 0..V_TOTAL-1 and wraps to 0.
  - `frame_end` is combinational: `h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1`.
- Arbitration (combinational, one push per cycle):
  - `full = (level==DEPTH)`, taken from the registered level before any same-cycle pop. A slot freed by a pop is usable next cycle.
  - If `flush` or `full`, both readies are 0.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester pointed to by `rr_ptr` is granted. `rr_ptr` then moves to the other requester.
  - `rr_ptr` changes only on a grant.
  - `x_ready` may depend on `x_valid`. A requester must hold valid and code until ready.
- Pop / presentation, evaluated on the `frame_end` edge:
  - If `!flush && hold_rem==0 && level!=0`: `code <= head`, head advances, and `hold_rem <= max(hold_frames,1)-1`.
  - Else if `hold_rem!=0`: `hold_rem` decrements.
  - `vga` samples the old `code` on this same edge. A popped code is therefore latched by `vga` one frame later and is visible in the following frame.
  - `code` is stable for whole frames and never changes mid-frame.
- Simultaneous push and pop: both happen. `level` is unchanged, and the FIFO write/read pointers both advance.
- Empty at pop time: `code` holds its previous value and `hold_rem` stays 0. The next non-empty frame end pops.
- Flush:
  - Clears `level`, pointers and `hold_rem` at the next edge.
  - Leaves `code` and the frame counters unchanged.
  - Blocks push and pop in the same cycle.
- Pointer wrap is modulo DEPTH. `level` is range 0..DEPTH and never overflows or underflows by construction.

Decomposition:
- Shared package `vga_pkg`: `H_TOTAL`, `V_TOTAL`, the visible and porch boundary constants (800/856/976/1040, 600/637/643/666), `CODE_W`, and the left/right RGB field slices. The same constants are used by `vga`.
- One sub-module: `sync_fifo` (`CODE_W` by `DEPTH`, push/pop, full/empty, level).
- Arbiter, hold timer and frame counter stay in the top module.

Test Plan:
- Reset release, then idle for 2 frames -> `code==0`, `level==0`, and `frame_end` pulses every 692640 cycles, first at cycle 692639.
- A pushes 0xF00_0F0 mid-frame 0 with `hold_frames=1` -> `a_ready` high for 1 cycle, `level=1`. At the first `frame_end` edge `code` becomes 0xF000F0 and `level` returns to 0.
- A and B both valid continuously with codes 0x111111/0x222222 -> grants alternate A,B,A,B and stop at `level=4`, with both readies 0. Each subsequent `frame_end` frees one slot, refilled on the next cycle.
- Queue 0xAAA555, 0x555AAA with `hold_frames=3` -> the first pops at frame end 1 and the second at frame end 4, never earlier.
- `hold_frames=0` with 2 queued -> behaves as 1, popping on consecutive frame ends.
- Assert `flush` with `level=3` and `code=0x123456` -> the next cycle has `level=0` and `code` still 0x123456. A `frame_end` coinciding with `flush` pops nothing. Assert `rst_n` low mid-frame -> all outputs immediately return to their reset values.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: timing constants and colour-code field helpers shared by vga and vga_code_sched
package vga_pkg;
    localparam int CODE_W      = 24;
    localparam int H_VISIBLE   = 800;
    localparam int H_SYNC_BEG  = 856;
    localparam int H_SYNC_END  = 976;
    localparam int H_TOTAL     = 1040;
    localparam int V_VISIBLE   = 600;
    localparam int V_SYNC_BEG  = 637;
    localparam int V_SYNC_END  = 643;
    localparam int V_TOTAL     = 666;
    localparam int LEFT_MSB    = 23;
    localparam int LEFT_LSB    = 12;
    localparam int RIGHT_MSB   = 11;
    localparam int RIGHT_LSB   = 0;

    function automatic logic [11:0] code_left(input logic [CODE_W-1:0] c);
        return c[LEFT_MSB:LEFT_LSB];
    endfunction

    function automatic logic [11:0] code_right(input logic [CODE_W-1:0] c);
        return c[RIGHT_MSB:RIGHT_LSB];
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count and synchronous flush
module sync_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [LW-1:0] r_lvl;

    assign dout  = r_mem[r_rp];
    assign full  = (r_lvl == LW'(DEPTH));
    assign empty = (r_lvl == '0);
    assign level = r_lvl;

    // storage is not reset; only the pointers decide what is valid
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wp] <= din;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_lvl <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_lvl <= '0;
        end else begin
            r_wp  <= r_wp + AW'(push);
            r_rp  <= r_rp + AW'(pop);
            r_lvl <= r_lvl + LW'(push) - LW'(pop);
        end
    end
endmodule

// File: rtl/vga_code_sched.sv
// vga_code_sched: arbitrates two code requesters into a FIFO and presents one code per hold period at frame boundaries
module vga_code_sched #(
    parameter int CODE_W  = vga_pkg::CODE_W,
    parameter int DEPTH   = 4,
    parameter int H_TOTAL = vga_pkg::H_TOTAL,
    parameter int V_TOTAL = vga_pkg::V_TOTAL,
    parameter int LW      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [CODE_W-1:0] a_code,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [CODE_W-1:0] b_code,
    output logic              b_ready,
    input  logic [7:0]        hold_frames,
    input  logic              flush,
    output logic [CODE_W-1:0] code,
    output logic              frame_end,
    output logic [LW-1:0]     level
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

    logic [HW-1:0]     r_h;
    logic [VW-1:0]     r_v;
    logic [7:0]        r_hold;
    logic              r_rr;
    logic [CODE_W-1:0] r_code;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_both;
    logic [CODE_W-1:0] w_head;
    logic [7:0]        w_hold_load;

    assign frame_end   = (r_h == H_LAST) && (r_v == V_LAST);
    assign w_both      = a_valid && b_valid;
    assign a_ready     = rst_n && !flush && !w_full && a_valid && (!b_valid || r_rr == RR_A);
    assign b_ready     = rst_n && !flush && !w_full && b_valid && (!a_valid || r_rr == RR_B);
    assign w_pop       = frame_end && !flush && (r_hold == 8'd0) && !w_empty;
    assign w_hold_load = (hold_frames == 8'd0) ? 8'd0 : hold_frames - 8'd1;
    assign code        = r_code;

    sync_fifo #(.W(CODE_W), .DEPTH(DEPTH), .LW(LW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (a_ready || b_ready),
        .pop   (w_pop),
        .din   (a_ready ? a_code : b_code),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    // free-running frame timing, aligned with vga by the shared reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            r_h <= (r_h == H_LAST) ? '0 : r_h + 1'b1;
            r_v <= (r_h != H_LAST) ? r_v : (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end
    end

    // round-robin pointer only moves when both requesters contend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rr <= RR_A;
        else if (w_both && (a_ready || b_ready)) r_rr <= a_ready ? RR_B : RR_A;
    end

    // pop at frame end once the hold period has expired, otherwise count it down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= '0;
            r_hold <= '0;
        end else if (flush) begin
            r_hold <= '0;
        end else if (w_pop) begin
            r_code <= w_head;
            r_hold <= w_hold_load;
        end else if (frame_end && r_hold != 8'd0) begin
            r_hold <= r_hold - 8'd1;
        end
    end
endmodule

// File: tb/tb_vga_code_sched.sv
// tb_vga_code_sched: directed self-checking bench using a shrunken frame (8x4 = 32 cycles)
module tb_vga_code_sched;
    localparam int HT = 8;
    localparam int VT = 4;
    localparam int FRAME = HT * VT;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        a_valid = 0;
    logic [23:0] a_code = 0;
    logic        a_ready;
    logic        b_valid = 0;
    logic [23:0] b_code = 0;
    logic        b_ready;
    logic [7:0]  hold_frames = 8'd1;
    logic        flush = 0;
    logic [23:0] code;
    logic        frame_end;
    logic [2:0]  level;

    int checks = 0;
    int failures = 0;

    vga_code_sched #(.CODE_W(24), .DEPTH(4), .H_TOTAL(HT), .V_TOTAL(VT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_code(a_code), .a_ready(a_ready),
        .b_valid(b_valid), .b_code(b_code), .b_ready(b_ready),
        .hold_frames(hold_frames), .flush(flush),
        .code(code), .frame_end(frame_end), .level(level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid = 0; b_valid = 0; flush = 0; hold_frames = 8'd1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic wait_fe();
        int n = 0;
        step();
        while (!frame_end && n < 2 * FRAME) begin
            step();
            n++;
        end
        checks++;
        if (!frame_end) begin
            failures++;
            $display("FAIL wait_fe: frame_end=%0b required=1 (timeout)", frame_end);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (code !== 24'h0 || level !== 3'd0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: code=%h level=%0d ar=%b br=%b required 0", code, level, a_ready, b_ready);
        end
        for (int i = 1; i <= 2 * FRAME + 2; i++) begin
            step();
            checks++;
            if (frame_end !== ((i == FRAME - 1) || (i == 2 * FRAME - 1))) begin
                failures++;
                $display("FAIL frame_end_timing: cycle=%0d frame_end=%b", i, frame_end);
            end
        end
        checks++;
        if (code !== 24'h0 || level !== 3'd0) begin
            failures++;
            $display("FAIL idle_state: code=%h level=%0d required 0/0", code, level);
        end
    endtask

    task automatic test_single_push();
        do_reset();
        step(); step();
        hold_frames = 8'd1; a_code = 24'hF000F0; a_valid = 1;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL push_ready: ar=%b br=%b required 1/0", a_ready, b_ready);
        end
        step();
        a_valid = 0;
        #1;
        checks++;
        if (level !== 3'd1 || a_ready !== 1'b0) begin
            failures++;
            $display("FAIL push_level: level=%0d ar=%b required 1/0", level, a_ready);
        end
        wait_fe();
        checks++;
        if (code !== 24'h0) begin
            failures++;
            $display("FAIL pre_pop_code: code=%h required 000000", code);
        end
        step();
        checks++;
        if (code !== 24'hF000F0 || level !== 3'd0) begin
            failures++;
            $display("FAIL pop_code: code=%h level=%0d required f000f0/0", code, level);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        a_code = 24'h111111; b_code = 24'h222222; a_valid = 1; b_valid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
                failures++;
                $display("FAIL rr_grant%0d: ar=%b br=%b required %b/%b", i, a_ready, b_ready, i % 2 == 0, i % 2 == 1);
            end
            step();
        end
        checks++;
        if (level !== 3'd4 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_stall: level=%0d ar=%b br=%b required 4/0/0", level, a_ready, b_ready);
        end
        wait_fe();
        step();
        checks++;
        if (code !== 24'h111111 || level !== 3'd3 || a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL refill1: code=%h level=%0d ar=%b br=%b required 111111/3/1/0", code, level, a_ready, b_ready);
        end
        step();
        checks++;
        if (level !== 3'd4 || a_ready !== 1'b0) begin
            failures++;
            $display("FAIL refilled: level=%0d ar=%b required 4/0", level, a_ready);
        end
        wait_fe();
        step();
        checks++;
        if (code !== 24'h222222 || level !== 3'd3 || b_ready !== 1'b1 || a_ready !== 1'b0) begin
            failures++;
            $display("FAIL refill2: code=%h level=%0d ar=%b br=%b required 222222/3/0/1", code, level, a_ready, b_ready);
        end
        a_valid = 0; b_valid = 0;
    endtask

    task automatic test_hold();
        do_reset();
        hold_frames = 8'd3;
        a_code = 24'hAAA555; a_valid = 1;
        step();
        a_code = 24'h555AAA;
        step();
        a_valid = 0;
        checks++;
        if (level !== 3'd2) begin
            failures++;
            $display("FAIL hold_fill: level=%0d required 2", level);
        end
        for (int f = 1; f <= 4; f++) begin
            wait_fe();
            step();
            checks++;
            if (code !== ((f < 4) ? 24'hAAA555 : 24'h555AAA)) begin
                failures++;
                $display("FAIL hold_fe%0d: code=%h required %h", f, code, (f < 4) ? 24'hAAA555 : 24'h555AAA);
            end
        end
    endtask

    task automatic test_hold_zero();
        do_reset();
        hold_frames = 8'd0;
        b_code = 24'h0AB0CD; b_valid = 1;
        step();
        b_code = 24'h0CD0AB;
        step();
        b_valid = 0;
        wait_fe();
        step();
        checks++;
        if (code !== 24'h0AB0CD || level !== 3'd1) begin
            failures++;
            $display("FAIL hold0_fe1: code=%h level=%0d required 0ab0cd/1", code, level);
        end
        wait_fe();
        step();
        checks++;
        if (code !== 24'h0CD0AB || level !== 3'd0) begin
            failures++;
            $display("FAIL hold0_fe2: code=%h level=%0d required 0cd0ab/0", code, level);
        end
    endtask

    task automatic test_flush_and_reset();
        do_reset();
        a_code = 24'h123456; a_valid = 1;
        step();
        a_valid = 0;
        wait_fe();
        step();
        for (int i = 1; i <= 3; i++) begin
            a_code = 24'(i); a_valid = 1;
            step();
        end
        a_valid = 1; flush = 1;
        #1;
        checks++;
        if (level !== 3'd3 || code !== 24'h123456 || a_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_pre: level=%0d code=%h ar=%b required 3/123456/0", level, code, a_ready);
        end
        step();
        flush = 0; a_valid = 0;
        checks++;
        if (level !== 3'd0 || code !== 24'h123456) begin
            failures++;
            $display("FAIL flush_post: level=%0d code=%h required 0/123456", level, code);
        end
        a_code = 24'h654321; a_valid = 1;
        step();
        a_valid = 0;
        wait_fe();
        flush = 1;
        step();
        flush = 0;
        checks++;
        if (level !== 3'd0 || code !== 24'h123456) begin
            failures++;
            $display("FAIL flush_at_fe: level=%0d code=%h required 0/123456", level, code);
        end
        wait_fe();
        step();
        checks++;
        if (code !== 24'h123456) begin
            failures++;
            $display("FAIL empty_fe: code=%h required 123456", code);
        end
        a_code = 24'h777777; a_valid = 1;
        step();
        step();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (code !== 24'h0 || level !== 3'd0 || a_ready !== 1'b0 || b_ready !== 1'b0 || frame_end !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: code=%h level=%0d ar=%b br=%b fe=%b required all 0", code, level, a_ready, b_ready, frame_end);
        end
        a_valid = 0;
        @(negedge clk);
        rst_n = 1;
        wait_fe();
        step();
        checks++;
        if (code !== 24'h0 || level !== 3'd0) begin
            failures++;
            $display("FAIL reset_discard: code=%h level=%0d required 0/0", code, level);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_back_to_back();
        test_hold();
        test_hold_zero();
        test_flush_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
